// File: rtl/gptp_tx_ts_buffer_pkg.sv
// gPTP transmit-timestamp buffer: shared types and helpers.
//   GPTP_DW       default descriptor / timestamp width
//   gptp_state_t  request sequencer state encoding
//   to_cnt_width  width of the response watchdog counter for a given timeout
package gptp_tx_ts_buffer_pkg;

    localparam int GPTP_DW = 80;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } gptp_state_t;

    // The counter only has to reach TO_CYC-1; keep at least one bit.
    function automatic int to_cnt_width(input int to_cyc);
        return (to_cyc > 2) ? $clog2(to_cyc) : 1;
    endfunction

endpackage

// File: rtl/gptp_tx_ts_buffer_if.sv
// gPTP transmit-timestamp buffer bus bundle.
//   req_*   gPTP engine -> buffer request channel (valid/ready)
//   send_*  buffer -> MAC-side send channel (valid/ready)
//   rsp_*   MAC-side -> buffer timestamp response strobe
// Modports: slave = buffer side, master = engine/MAC side.
interface gptp_tx_ts_buffer_if
    import gptp_tx_ts_buffer_pkg::*;
#(
    parameter int DW = GPTP_DW,
    parameter int AW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;

    logic          send_valid;
    logic          send_ready;
    logic [AW-1:0] send_addr;
    logic [DW-1:0] send_data;

    logic          rsp_valid;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready,
        output send_valid, send_addr, send_data,
        input  send_ready,
        input  rsp_valid, rsp_addr, rsp_data
    );

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready,
        input  send_valid, send_addr, send_data,
        output send_ready,
        output rsp_valid, rsp_addr, rsp_data
    );
endinterface

// File: rtl/gptp_tx_ts_buffer_fifo.sv
// Synchronous FIFO for queued gPTP requests.
//   clk, reset          clock, synchronous active-high reset (flushes)
//   push, push_data     write strobe and word (ignored when full)
//   pop, pop_data       read strobe and head word (ignored when empty)
//   full, empty, level  occupancy status
// Pointers carry one extra MSB so full and empty are distinguishable.
module gptp_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic [PW:0]  level
);
    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign level    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
    end
endmodule

// File: rtl/gptp_tx_ts_buffer.sv
// gPTP transmit-timestamp buffer.
// Queues transmit requests, issues them one at a time on the send channel,
// waits (watchdog-bounded) for the matching timestamp response and stores it
// in a DEPTH-entry store with per-slot valid flags and clear-on-read.
//   clk, reset            clock, synchronous active-high reset
//   bus (slave)           req_*, send_*, rsp_* channels
//   rd_addr/rd_clr        store read slot and valid-clear strobe
//   rd_data/rd_hit        stored timestamp (0 unless valid) and valid flag
//   cmp_valid/cmp_addr    response stored / slot that completed or timed out
//   to_pulse              response watchdog expired
//   stray_pulse           response dropped (unexpected or wrong slot)
//   ovw_pulse             store overwrote a still-valid slot
//   q_level               request FIFO occupancy
//
// state   | meaning
// IDLE    | nothing in flight; pop FIFO head if present
// SEND    | send_valid high, holding addr/data until send_ready
// WAIT    | watchdog running, waiting for rsp on cur_addr
module gptp_tx_ts_buffer
    import gptp_tx_ts_buffer_pkg::*;
#(
    parameter int DW     = GPTP_DW,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int QDEPTH = 4,
    parameter int TO_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    gptp_tx_ts_buffer_if.slave       bus,
    input  logic [AW-1:0]            rd_addr,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_hit,
    input  logic                     rd_clr,
    output logic                     cmp_valid,
    output logic [AW-1:0]            cmp_addr,
    output logic                     to_pulse,
    output logic                     stray_pulse,
    output logic                     ovw_pulse,
    output logic [$clog2(QDEPTH):0]  q_level
);
    localparam int QW = AW + DW;
    localparam int CW = to_cnt_width(TO_CYC);
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    gptp_state_t   state;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic [CW-1:0] to_cnt;
    logic          send_valid_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [QW-1:0] fifo_head;

    logic [DW-1:0]    ts_mem [DEPTH];
    logic [DEPTH-1:0] ts_valid;

    logic rsp_in_range;
    logic rd_in_range;
    logic rsp_hit;

    assign bus.req_ready  = ~reset & ~fifo_full;
    assign bus.send_valid = send_valid_q;
    assign bus.send_addr  = cur_addr;
    assign bus.send_data  = cur_data;

    assign fifo_pop = (state == ST_IDLE) & ~fifo_empty;

    gptp_sync_fifo #(
        .W     (QW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.req_valid & bus.req_ready),
        .push_data ({bus.req_addr, bus.req_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (q_level)
    );

    // Slots >= DEPTH only exist when DEPTH is not a power of two; such
    // responses are treated as strays and the request runs into the watchdog.
    assign rsp_in_range = int'(bus.rsp_addr) < DEPTH;
    assign rd_in_range  = int'(rd_addr) < DEPTH;
    assign rsp_hit      = (state == ST_WAIT) & bus.rsp_valid & rsp_in_range
                        & (bus.rsp_addr == cur_addr);

    assign rd_hit  = rd_in_range & ts_valid[rd_addr];
    assign rd_data = rd_hit ? ts_mem[rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur_addr     <= '0;
            cur_data     <= '0;
            to_cnt       <= '0;
            send_valid_q <= 1'b0;
            cmp_valid    <= 1'b0;
            cmp_addr     <= '0;
            to_pulse     <= 1'b0;
            stray_pulse  <= 1'b0;
            ovw_pulse    <= 1'b0;
            ts_valid     <= '0;
        end else begin
            cmp_valid   <= 1'b0;
            to_pulse    <= 1'b0;
            stray_pulse <= bus.rsp_valid & ~rsp_hit;
            ovw_pulse   <= rsp_hit & ts_valid[bus.rsp_addr];

            // A store beats a clear aimed at the same slot.
            for (int i = 0; i < DEPTH; i++) begin
                if (rsp_hit && int'(bus.rsp_addr) == i)
                    ts_valid[i] <= 1'b1;
                else if (rd_clr && int'(rd_addr) == i)
                    ts_valid[i] <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {cur_addr, cur_data} <= fifo_head;
                        send_valid_q         <= 1'b1;
                        state                <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.send_ready) begin
                        send_valid_q <= 1'b0;
                        to_cnt       <= '0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Response is checked first so it wins over a same-cycle timeout.
                    if (rsp_hit) begin
                        cmp_valid <= 1'b1;
                        cmp_addr  <= cur_addr;
                        state     <= ST_IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        to_pulse <= 1'b1;
                        cmp_addr <= cur_addr;
                        state    <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_hit) ts_mem[bus.rsp_addr] <= bus.rsp_data;
    end
endmodule

// File: doc/gptp_tx_ts_buffer.md
Name: gptp_tx_ts_buffer

Overview:
Parametrised successor of the gPTP transmit-timestamp buffer. Queues gPTP transmit requests (slot address + descriptor) in a request FIFO and issues them one at a time to the MAC-side logic over a valid/ready send channel. It waits for the matching timestamp response, bounded by a watchdog timeout, and captures the response into a DEPTH-entry timestamp store. The store has per-entry valid flags and clear-on-read, read by the gPTP engine.

Parameters:
DW, 80, width of request descriptor and timestamp data
DEPTH, 8, number of timestamp slots
AW, $clog2(DEPTH), binary slot address width
QDEPTH, 4, request FIFO depth (power of 2, >=2)
TO_CYC, 1024, cycles waited for a response before abort (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  gPTP request valid
req_ready  out  1  request FIFO not full
req_addr  in  AW  target timestamp slot
req_data  in  DW  descriptor forwarded to send_data
send_valid  out  1  request to MAC logic
send_ready  in  1  MAC logic accepts
send_addr  out  AW  slot of in-flight request
send_data  out  DW  descriptor of in-flight request
rsp_valid  in  1  timestamp response strobe
rsp_addr  in  AW  slot the response belongs to
rsp_data  in  DW  timestamp
rd_addr  in  AW  read slot
rd_data  out  DW  stored timestamp (combinational)
rd_hit  out  1  valid flag of rd_addr slot
rd_clr  in  1  clear valid flag of rd_addr slot
cmp_valid  out  1  one-cycle pulse: response stored
cmp_addr  out  AW  slot completed/timed out
to_pulse  out  1  one-cycle pulse: response timeout
stray_pulse  out  1  one-cycle pulse: unexpected response dropped
ovw_pulse  out  1  one-cycle pulse: stored over a still-valid slot
q_level  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset: FIFO empty, all valid flags 0, state IDLE, counter 0, every output pulse/valid 0. req_ready=0 while reset is high and 1 in the first cycle after. Store data is don't-care; rd_data is masked to 0 when rd_hit=0.
- Request accept on req_valid&req_ready; simultaneous push and pop allowed when full (pop frees space next cycle; req_ready stays combinational !full only).
- FSM IDLE: FIFO non-empty -> pop head into cur_addr/cur_data registers, go SEND. Send_valid rises one cycle after pop, so latency from accept into an empty FIFO to send_valid is 2 cycles.
- SEND: send_valid=1, send_addr/send_data stable until send_ready. On handshake go WAIT, clear counter.
- WAIT: counter increments each cycle.
  - rsp_valid with rsp_addr==cur_addr -> write rsp_data to slot, set valid, cmp_valid/cmp_addr pulse next cycle, go IDLE.
  - Counter reaches TO_CYC-1 without a response -> to_pulse and cmp_addr=cur_addr next cycle, slot untouched, go IDLE.
  - A response in the same cycle as the timeout wins (stored, no to_pulse).
- rsp_valid in IDLE/SEND, or with mismatched addr in WAIT: dropped, stray_pulse next cycle, store unchanged.
- Storing into a slot whose valid=1: overwrite, ovw_pulse next cycle.
- rd_clr: clears valid[rd_addr] at clock edge. Same-cycle store to the same slot: store wins (valid stays 1, new data). Different slots: both take effect.
- Only one request in flight; order strictly FIFO. Back-to-back: IDLE re-entered for one cycle between requests.
- Reset mid-WAIT/SEND: abandon in-flight request, flush FIFO, no pulses emitted.
- Out-of-range addresses (DEPTH not a power of 2, addr>=DEPTH): request still sent, response stored nowhere, stray_pulse asserted.

Decomposition:
- gptp_pkg: DW default, state enum (IDLE, SEND, WAIT), TO counter width helper.
- One sub-module: gptp_sync_fifo (parametrised DW+AW wide, QDEPTH deep, wrap-around pointers with extra MSB for full/empty, level output).
- Store: DEPTH registers + valid vector inline.

Test Plan:
- Reset, single req addr=3 data=0xA5, send_ready=1, rsp addr=3 data=0x1234 after 5 cycles -> send_valid cycle 2, cmp_valid addr=3, rd_addr=3 gives rd_hit=1, rd_data=0x1234; rd_clr -> rd_hit=0 next cycle.
- Push 5 reqs with QDEPTH=4 and send_ready=0 -> req_ready=0 after 4 accepted plus 1 popped into SEND; sends issue in order 0,1,2,3,4 once send_ready=1.
- No response, TO_CYC=16 -> to_pulse exactly 16 cycles after send handshake, cmp_addr=cur, slot valid unchanged, next request issued.
- rsp addr=5 while waiting on addr=2, then rsp addr=2 -> stray_pulse once, only slot 2 written.
- rd_clr on slot 4 same cycle as rsp for slot 4 -> rd_hit=1 with new data; second response to slot 4 -> ovw_pulse.
- Reset asserted mid-WAIT with 2 queued -> q_level=0, send_valid=0, no cmp/to pulses afterwards.
